regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 15 +
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_write_arbiter_rr_arbiter_2.sv | 18 +
 rtl/regfile_write_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter slice.
// Holds the default widths and register count, and the arbiter FSM state
// encoding. No ports; imported by the interface, arbiter and top.
package regfile_write_arbiter_pkg;

    localparam int DEF_DATA_W   = 16;  // register data width
    localparam int DEF_ADDR_W   = 5;   // register address width
    localparam int DEF_NUM_REGS = 32;  // registers zeroed by a clear sequence

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-request bundle for two requesters sharing one register-file port.
// Signals per requester i: reqi_valid, reqi_addr, reqi_data (requester
// driven) and reqi_ready (arbiter driven; a transfer is valid && ready).
// Modports: master = requester side, slave = arbiter side.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports: valid[1:0] - request lines; prio - requester favoured when both
// request (0 or 1); grant[1:0] - one-hot or zero grant, never to an
// idle requester.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant    = '0;
        // A lone requester wins outright; prio only breaks ties.
        grant[0] = valid[0] & (~valid[1] | ~prio);
        grant[1] = valid[1] & (~valid[0] |  prio);
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for a register file with a bulk-clear sequence and
// read bypass.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   req                - two write requesters (valid/ready/addr/data)
//   clr_start          - one-cycle request to zero every register
//   clr_done, busy     - clear completed pulse / clear in progress
//   Rw, WrEn, busW     - registered register-file write port
//   Ra, Rb             - read addresses (also presented to the file)
//   rf_busA, rf_busB   - raw register-file read data
//   busA, busB         - read data with same-cycle write forwarded
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  req,
    input  logic                    clr_start,
    output logic                    clr_done,
    output logic                    busy,
    output logic [ADDR_W-1:0]       Rw,
    output logic                    WrEn,
    output logic [DATA_W-1:0]       busW,
    input  logic [ADDR_W-1:0]       Ra,
    input  logic [ADDR_W-1:0]       Rb,
    input  logic [DATA_W-1:0]       rf_busA,
    input  logic [DATA_W-1:0]       rf_busB,
    output logic [DATA_W-1:0]       busA,
    output logic [DATA_W-1:0]       busB
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] busw_q, busw_d;
    logic              clr_done_q, clr_done_d;
    logic              busy_q, busy_d;

    logic [1:0] valid;
    logic [1:0] grant;
    logic       grant_en;

    assign valid = {req.req1_valid, req.req0_valid};

    rr_arbiter_2 u_rr (
        .valid (valid),
        .prio  (prio_q),
        .grant (grant)
    );

    // Grants only reach the requesters in IDLE without a pending clear,
    // and never while reset is held.
    assign req.req0_ready = grant[0] & grant_en & ~rst;
    assign req.req1_ready = grant[1] & grant_en & ~rst;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        wren_d     = 1'b0;
        rw_d       = rw_q;
        busw_d     = busw_q;
        clr_done_d = 1'b0;
        grant_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    wren_d  = 1'b1;
                    rw_d    = '0;
                    busw_d  = '0;
                end else begin
                    grant_en = 1'b1;
                    if (grant[0]) begin
                        wren_d = 1'b1;
                        rw_d   = req.req0_addr;
                        busw_d = req.req0_data;
                        prio_d = 1'b1;
                    end else if (grant[1]) begin
                        wren_d = 1'b1;
                        rw_d   = req.req1_addr;
                        busw_d = req.req1_data;
                        prio_d = 1'b0;
                    end
                end
            end
            CLEAR: begin
                // The write port is registered, so each cycle loads the
                // address the next CLEAR cycle presents (cnt + 1).
                if (cnt_q == LAST_IDX) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    wren_d = 1'b1;
                    rw_d   = cnt_q + 1'b1;
                    busw_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prio_q     <= 1'b0;
            wren_q     <= 1'b0;
            rw_q       <= '0;
            busw_q     <= '0;
            clr_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            wren_q     <= wren_d;
            rw_q       <= rw_d;
            busw_q     <= busw_d;
            clr_done_q <= clr_done_d;
            busy_q     <= busy_d;
        end
    end

    assign WrEn     = wren_q;
    assign Rw       = rw_q;
    assign busW     = busw_q;
    assign clr_done = clr_done_q;
    assign busy     = busy_q;

    // Forward the write in flight so a same-cycle read sees the new value.
    assign busA = (wren_q && (Ra == rw_q)) ? busw_q : rf_busA;
    assign busB = (wren_q && (Rb == rw_q)) ? busw_q : rf_busB;

endmodule
